adder_tree_acc_pipe: RTL

//  Parametrised, fully pipelined signed adder tree: sums NUM_IN two's-complement WIDTH-bit

---
 rtl/adder_tree_acc_pipe.sv | 128 ++++++++++++
 1 files changed

// File: rtl/adder_tree_acc_pipe.sv
`default_nettype none
// ============================================================================
// Module      : adder_tree_acc_pipe
// Description : Pipelined signed NUM_IN-operand adder tree with a valid flag
//               and an optional saturating running accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_tree_acc_pipe #(
    parameter int WIDTH     = 12,
    parameter int NUM_IN    = 8,
    parameter int ACC_GUARD = 4,
    localparam int LVL      = $clog2(NUM_IN),
    localparam int SUM_W    = WIDTH + LVL,
    localparam int ACC_W    = SUM_W + ACC_GUARD
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [NUM_IN*WIDTH-1:0] din,
    input  logic                    acc_mode,
    input  logic                    acc_clr,
    output logic                    out_valid,
    output logic [SUM_W-1:0]        sum,
    output logic                    acc_valid,
    output logic [ACC_W-1:0]        acc_sum,
    output logic                    acc_ovf
);

    // Bit offset of tree level l inside the flat tree register; level l holds
    // NUM_IN>>l operands of WIDTH+l bits each.
    function automatic int lvl_off(input int l);
        int o;
        o = 0;
        for (int m = 0; m < l; m++) begin
            o += (NUM_IN >> m) * (WIDTH + m);
        end
        return o;
    endfunction

    localparam int TREE_W = lvl_off(LVL + 1);
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [TREE_W-1:0] tree_q, tree_d;
    logic [LVL:0]      vld_q, mode_q, clr_q;

    assign tree_d[NUM_IN*WIDTH-1:0] = din;

    generate
        for (genvar l = 1; l <= LVL; l++) begin : g_lvl
            localparam int OW   = WIDTH + l;
            localparam int IW   = OW - 1;
            localparam int IOFF = lvl_off(l - 1);
            localparam int OOFF = lvl_off(l);
            for (genvar j = 0; j < (NUM_IN >> l); j++) begin : g_pair
                logic [IW-1:0] lhs, rhs;
                assign lhs = tree_q[IOFF + (2*j)*IW +: IW];
                assign rhs = tree_q[IOFF + (2*j+1)*IW +: IW];
                assign tree_d[OOFF + j*OW +: OW] = {lhs[IW-1], lhs} + {rhs[IW-1], rhs};
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tree_q <= '0;
            vld_q  <= '0;
            mode_q <= '0;
            clr_q  <= '0;
        end else begin
            tree_q <= tree_d;
            vld_q  <= {vld_q[LVL-1:0], in_valid};
            mode_q <= {mode_q[LVL-1:0], acc_mode};
            clr_q  <= {clr_q[LVL-1:0], acc_clr};
        end
    end

    assign sum       = tree_q[TREE_W-1 -: SUM_W];
    assign out_valid = vld_q[LVL];

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             accv_q, accv_d;
    logic [ACC_W-1:0] sum_ext;
    logic [ACC_W:0]   acc_wide;
    logic             sat;

    assign sum_ext  = {{ACC_GUARD{sum[SUM_W-1]}}, sum};
    assign acc_wide = {acc_q[ACC_W-1], acc_q} + {sum_ext[ACC_W-1], sum_ext};
    // Two top bits disagree exactly when the ACC_W-bit result would wrap.
    assign sat      = acc_wide[ACC_W] ^ acc_wide[ACC_W-1];

    always_comb begin
        acc_d  = acc_q;
        ovf_d  = ovf_q;
        accv_d = 1'b0;
        if (vld_q[LVL] && mode_q[LVL]) begin
            accv_d = 1'b1;
            if (clr_q[LVL]) begin
                acc_d = sum_ext;
                ovf_d = 1'b0;
            end else if (sat) begin
                acc_d = acc_wide[ACC_W] ? ACC_MIN : ACC_MAX;
                ovf_d = 1'b1;
            end else begin
                acc_d = acc_wide[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            accv_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            ovf_q  <= ovf_d;
            accv_q <= accv_d;
        end
    end

    assign acc_sum   = acc_q;
    assign acc_ovf   = ovf_q;
    assign acc_valid = accv_q;

endmodule
`default_nettype wire
